rtc_data_arbiter: RTL and testbench
===================================

Name: rtc_data_arbiter

Overview:
- Owns the RTC time/date/timer register bank: NREG BCD bytes, slot 0..8 = seconds, minutes, hours, year, month, day, timer s, timer m, timer h.
- Arbitrates writes from two requesters: the RTC refresh reader and the user edit unit.
- Writes land in a shadow bank. The shadow bank is copied to a display bank only after vertical blanking begins, so the character generator never shows a half-updated time.
- Sits between the RTC bus interface / edit logic and the character generator's read port (the port addressed by `pos`).

Parameters:
- NREG, 9, number of byte registers per bank.
- DW, 8, register width (two packed BCD digits).
- AW, 4, address width. Address values >= NREG are out of range (the char generator uses 9 for "no field").

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rtc_req  in  1  RTC reader write request; held until rtc_gnt is seen
- rtc_addr  in  AW  RTC write address
- rtc_wdata  in  DW  RTC write data
- rtc_gnt  out  1  one-cycle accept pulse to RTC reader
- ed_req  in  1  edit-unit write request; held until ed_gnt is seen
- ed_addr  in  AW  edit write address
- ed_wdata  in  DW  edit write data
- ed_gnt  out  1  one-cycle accept pulse to edit unit
- edit_lock  in  1  high while the user is in any edit mode
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- vid_addr  in  AW  display read address
- vid_data  out  DW  display bank data
- busy  out  1  high while a commit copy is in progress

Behaviour:
- Reset (synchronous, active-high):
  - Both banks cleared to 0x00.
  - rtc_gnt=0, ed_gnt=0, vid_data=0x00, busy=0, dirty=0, copy index=0, state=IDLE.
  - Reset asserted mid-COPY aborts the copy; display bank is cleared regardless of progress.
- Video read path:
  - vid_data is registered: 1-cycle latency from vid_addr.
  - Reads always come from the display bank, never the shadow bank.
  - vid_addr >= NREG gives 0x00.
  - Reads are valid in every state, including COPY: a slot already copied shows the new value, a slot not yet copied shows the old value.
- State machine, two states:
  - IDLE:
    - If frame_tick=1 and dirty=1: go to COPY, copy index=0, clear dirty. No grant this cycle; a pending request waits.
    - Otherwise, if any request is eligible: accept at most one per cycle.
  - COPY:
    - Each cycle: display[idx] <= shadow[idx], idx++.
    - After idx=NREG-1 is copied, return to IDLE. COPY lasts exactly NREG cycles.
    - busy=1 for the whole COPY state.
    - No grants in COPY; requests stall.
    - frame_tick in COPY is ignored.
- Write arbitration (IDLE only):
  - Fixed priority: edit unit over RTC.
  - A requester is eligible when its req=1 and its own gnt register is 0. This enforces a one-cycle gap and prevents a double write from a held req.
  - On the accepting edge, the selected data is written to shadow[addr] and the matching gnt register is set; gnt is high for exactly the next cycle.
  - Every accepted write sets dirty, including writes whose data equals the current value.
  - Out-of-range address: granted, data discarded, dirty unchanged.
  - edit_lock=1: RTC requests are still granted (the reader never stalls) but their data is discarded and dirty is unchanged. Edit writes are unaffected.
  - Both requesting in the same cycle: ed_gnt next cycle. The RTC request is accepted at the earliest following IDLE cycle.
- frame_tick with dirty=0: no commit, stay in IDLE, arbitration proceeds normally that cycle.
- dirty reflects only writes accepted after the last commit start.

Test Plan:
- Reset, then vid_addr=2 → vid_data=0x00 one cycle later; busy=0; both gnt=0.
- RTC write addr=2 data=0x15, then frame_tick → busy high for 9 cycles; afterwards vid_addr=2 → 0x15. Before the tick, vid_addr=2 still reads 0x00.
- ed_req and rtc_req asserted in the same cycle (ed addr=1 data=0x30, rtc addr=1 data=0x59) → ed_gnt first, rtc_gnt two cycles later; after commit, slot 1 = 0x59.
- edit_lock=1, RTC write addr=0 data=0x42 → rtc_gnt pulses; after frame_tick the display slot 0 is unchanged and no COPY occurs (dirty=0).
- rtc_req held during COPY → no rtc_gnt until busy falls, then rtc_gnt within 1 cycle; frame_tick mid-COPY does not extend busy beyond 9 cycles.
- reset pulse at copy index 4 → busy=0 next cycle, all display and shadow slots read 0x00; write to addr=9 → gnt pulse, no dirty, a later frame_tick causes no COPY.

Source files
------------

// File: rtl/rtc_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rtc_data_arbiter
// Purpose  : RTC time/date/timer register bank with two-requester write
//            arbitration (edit unit over RTC reader), a shadow bank for
//            writes and a display bank committed at vertical blanking so the
//            character generator never shows a half-updated time.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            rtc_req/addr/wdata, rtc_gnt - RTC reader write port
//            ed_req/addr/wdata,  ed_gnt  - edit unit write port
//            edit_lock        - discard RTC data while the user edits
//            frame_tick       - start of vertical blanking, triggers commit
//            vid_addr/vid_data - registered display bank read port
//            busy             - commit copy in progress
// Revision : 1.0 - initial release
// ============================================================================
module rtc_data_arbiter #(
    parameter int NREG = 9,
    parameter int DW   = 8,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rtc_req,
    input  logic [AW-1:0] rtc_addr,
    input  logic [DW-1:0] rtc_wdata,
    output logic          rtc_gnt,
    input  logic          ed_req,
    input  logic [AW-1:0] ed_addr,
    input  logic [DW-1:0] ed_wdata,
    output logic          ed_gnt,
    input  logic          edit_lock,
    input  logic          frame_tick,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          busy
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [AW-1:0] c_nreg_addr = AW'(NREG);
    localparam logic [IW-1:0] c_last_idx  = IW'(NREG - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_shadow  [NREG];
    logic [DW-1:0]   r_display [NREG];
    logic [IW-1:0]   r_idx;
    logic            r_dirty;
    logic            r_rtc_gnt;
    logic            r_ed_gnt;
    logic [DW-1:0]   r_vid_data;

    logic            w_commit;
    logic            w_acc_ed;
    logic            w_acc_rtc;
    logic [AW-1:0]   w_wr_addr;
    logic [DW-1:0]   w_wr_data;
    logic            w_wr_en;

    // Next-state and accept decisions. A commit start takes precedence over
    // arbitration, so no grant is issued on the cycle COPY begins. Gating
    // eligibility on the requester's own gnt register forces a one-cycle gap
    // and stops a still-held request from being written twice.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_acc_ed    = 1'b0;
        w_acc_rtc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_tick && r_dirty) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_COPY;
                end else if (ed_req && !r_ed_gnt) begin
                    w_acc_ed = 1'b1;
                end else if (rtc_req && !r_rtc_gnt) begin
                    w_acc_rtc = 1'b1;
                end
            end
            ST_COPY: begin
                if (r_idx == c_last_idx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // RTC data is granted but dropped under edit_lock so the reader keeps
    // running; out-of-range addresses are granted and dropped for everyone.
    always_comb begin
        w_wr_addr = w_acc_ed ? ed_addr  : rtc_addr;
        w_wr_data = w_acc_ed ? ed_wdata : rtc_wdata;
        w_wr_en   = (w_acc_ed || (w_acc_rtc && !edit_lock)) &&
                    (w_wr_addr < c_nreg_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_dirty    <= 1'b0;
            r_rtc_gnt  <= 1'b0;
            r_ed_gnt   <= 1'b0;
            r_vid_data <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_shadow[i]  <= '0;
                r_display[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_ed_gnt  <= w_acc_ed;
            r_rtc_gnt <= w_acc_rtc;

            if (w_commit) begin
                r_idx   <= '0;
                r_dirty <= 1'b0;
            end else if (w_wr_en) begin
                r_dirty <= 1'b1;
            end

            if (w_wr_en) begin
                r_shadow[w_wr_addr] <= w_wr_data;
            end

            // One slot per cycle; a read of a slot being copied this edge
            // still returns the old value, which is the intended behaviour.
            if (r_state == ST_COPY) begin
                r_display[r_idx] <= r_shadow[r_idx];
                r_idx            <= r_idx + 1'b1;
            end

            r_vid_data <= (vid_addr < c_nreg_addr) ? r_display[vid_addr] : '0;
        end
    end

    assign rtc_gnt  = r_rtc_gnt;
    assign ed_gnt   = r_ed_gnt;
    assign vid_data = r_vid_data;
    assign busy     = (r_state == ST_COPY);

endmodule
`default_nettype wire

// File: tb/tb_rtc_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_data_arbiter
// Purpose  : Self-checking bench for rtc_data_arbiter. A driver applies
//            directed then random stimulus, steps a behavioural model of the
//            register banks and pushes the expected outputs into a queue; a
//            monitor pops and compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_data_arbiter;

    localparam int NREG = 9;
    localparam int DW   = 8;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rtc_req;
    logic [AW-1:0] rtc_addr;
    logic [DW-1:0] rtc_wdata;
    logic          rtc_gnt;
    logic          ed_req;
    logic [AW-1:0] ed_addr;
    logic [DW-1:0] ed_wdata;
    logic          ed_gnt;
    logic          edit_lock;
    logic          frame_tick;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          busy;

    always #5 clk = ~clk;

    rtc_data_arbiter #(.NREG(NREG), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rtc_req    (rtc_req),
        .rtc_addr   (rtc_addr),
        .rtc_wdata  (rtc_wdata),
        .rtc_gnt    (rtc_gnt),
        .ed_req     (ed_req),
        .ed_addr    (ed_addr),
        .ed_wdata   (ed_wdata),
        .ed_gnt     (ed_gnt),
        .edit_lock  (edit_lock),
        .frame_tick (frame_tick),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .busy       (busy)
    );

    typedef struct packed {
        logic       rg;
        logic       eg;
        logic       busy;
        logic [7:0] vd;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: banks as plain arrays, commit as a countdown of
    // remaining slots, gnt as "granted on the previous edge".
    logic [7:0] m_sh [NREG];
    logic [7:0] m_dp [NREG];
    bit         m_dirty;
    int         m_left;
    bit         m_rg;
    bit         m_eg;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for grant t=%0t", name, $time);
    endtask

    task automatic model_step();
        exp_t e;
        int   s;
        e = '0;
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_sh[i] = 8'h00;
                m_dp[i] = 8'h00;
            end
            m_dirty = 0;
            m_left  = 0;
            m_rg    = 0;
            m_eg    = 0;
        end else begin
            e.vd = (int'(vid_addr) < NREG) ? m_dp[vid_addr] : 8'h00;
            if (m_left > 0) begin
                s       = NREG - m_left;
                m_dp[s] = m_sh[s];
                m_left--;
            end else if (frame_tick && m_dirty) begin
                m_left  = NREG;
                m_dirty = 0;
            end else if (ed_req && !m_eg) begin
                e.eg = 1'b1;
                if (int'(ed_addr) < NREG) begin
                    m_sh[ed_addr] = ed_wdata;
                    m_dirty       = 1;
                end
            end else if (rtc_req && !m_rg) begin
                e.rg = 1'b1;
                if (int'(rtc_addr) < NREG && !edit_lock) begin
                    m_sh[rtc_addr] = rtc_wdata;
                    m_dirty        = 1;
                end
            end
            m_eg   = e.eg;
            m_rg   = e.rg;
            e.busy = (m_left > 0);
        end
        q.push_back(e);
    endtask

    // One clock: pick a read address, predict, then advance past the edge.
    task automatic tick();
        vid_addr = AW'($urandom_range(0, 11));
        model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rtc_gnt",  {7'd0, rtc_gnt}, {7'd0, e.rg});
            chk("ed_gnt",   {7'd0, ed_gnt},  {7'd0, e.eg});
            chk("busy",     {7'd0, busy},    {7'd0, e.busy});
            chk("vid_data", vid_data,        e.vd);
        end
    end

    task automatic wr_rtc(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        rtc_addr = a; rtc_wdata = d; rtc_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!m_rg && n < 50);
        rtc_req = 1'b0;
        if (!m_rg) timeout("wr_rtc");
    endtask

    task automatic wr_ed(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        ed_addr = a; ed_wdata = d; ed_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!m_eg && n < 50);
        ed_req = 1'b0;
        if (!m_eg) timeout("wr_ed");
    endtask

    task automatic wr_both(input logic [AW-1:0] a, input logic [DW-1:0] de,
                           input logic [DW-1:0] dr);
        int n;
        ed_addr = a; ed_wdata = de; ed_req = 1'b1;
        rtc_addr = a; rtc_wdata = dr; rtc_req = 1'b1;
        n = 0;
        while ((ed_req || rtc_req) && n < 50) begin
            tick(); n++;
            if (m_eg) ed_req = 1'b0;
            if (m_rg) rtc_req = 1'b0;
        end
        if (ed_req || rtc_req) begin
            ed_req = 1'b0; rtc_req = 1'b0;
            timeout("wr_both");
        end
    endtask

    task automatic commit();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (NREG + 2) tick();
    endtask

    initial begin
        bit rtc_pend;
        bit ed_pend;
        reset = 1'b1; rtc_req = 1'b0; rtc_addr = '0; rtc_wdata = '0;
        ed_req = 1'b0; ed_addr = '0; ed_wdata = '0;
        edit_lock = 1'b0; frame_tick = 1'b0; vid_addr = '0;
        @(negedge clk);
        #1;
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();

        // Basic write, visible only after commit.
        wr_rtc(4'd2, 8'h15);
        repeat (3) tick();
        commit();

        // Simultaneous requests: edit wins, RTC follows and lands last.
        wr_both(4'd1, 8'h30, 8'h59);
        commit();

        // Locked RTC write: granted, dropped, no commit follows.
        edit_lock = 1'b1;
        wr_rtc(4'd0, 8'h42);
        commit();
        edit_lock = 1'b0;

        // RTC request held across a COPY, with a frame_tick mid-copy.
        wr_ed(4'd3, 8'h11);
        frame_tick = 1'b1; tick(); frame_tick = 1'b0;
        tick(); tick();
        frame_tick = 1'b1; tick(); frame_tick = 1'b0;
        wr_rtc(4'd4, 8'h22);
        commit();

        // Reset while copying slot 4.
        wr_ed(4'd5, 8'h45);
        frame_tick = 1'b1; tick(); frame_tick = 1'b0;
        repeat (4) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (12) tick();
        wr_rtc(4'd9, 8'h77);
        frame_tick = 1'b1; tick(); frame_tick = 1'b0;
        repeat (4) tick();

        // Random traffic.
        rtc_pend = 0;
        ed_pend  = 0;
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            frame_tick = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) edit_lock = ~edit_lock;
            if (m_rg) begin
                rtc_pend = 0;
                rtc_req  = $urandom_range(0, 1) == 1;
            end else if (!rtc_pend) begin
                rtc_req = ($urandom_range(0, 2) == 0);
                if (rtc_req) begin
                    rtc_pend  = 1;
                    rtc_addr  = AW'($urandom_range(0, 10));
                    rtc_wdata = DW'($urandom);
                end
            end
            if (m_eg) begin
                ed_pend = 0;
                ed_req  = $urandom_range(0, 1) == 1;
            end else if (!ed_pend) begin
                ed_req = ($urandom_range(0, 5) == 0);
                if (ed_req) begin
                    ed_pend  = 1;
                    ed_addr  = AW'($urandom_range(0, 10));
                    ed_wdata = DW'($urandom);
                end
            end
            tick();
        end

        reset = 1'b0; rtc_req = 1'b0; ed_req = 1'b0; frame_tick = 1'b0;
        repeat (NREG + 3) tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
